// File: rtl/cache_fill_fsm.sv
// Cache line fill engine: on a miss, fetches LINE_WORDS 16-bit words from memory
// and streams them into the data array, writing the tag with the last word.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the fill at the missing word.
module cache_fill_fsm #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_ready,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data_in,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [15:0]       fill_data,
    output logic              write_tag_array
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 1;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    issue_cnt, issue_cnt_nxt;
    logic [CNT_W-1:0]    recv_cnt, recv_cnt_nxt;
    logic                issue_done, issue_done_nxt;
    logic [ADDR_W-1:0]   line_base, line_base_nxt;
    logic [CNT_W-1:0]    start_off;
    logic [CNT_W-1:0]    issue_word, recv_word;
    logic                issue_fire;
    logic                unused_bits;

    assign unused_bits = ^miss_address[OFF_W-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    // Word offset of the missing access, latched with the miss so both sides wrap from it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_off <= '0;
        end else if (state == IDLE && miss_detected) begin
            start_off <= miss_address[OFF_W-1:1];
        end
    end
`else
    assign start_off = '0;
`endif

    assign issue_word = start_off + issue_cnt;
    assign recv_word  = start_off + recv_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            issue_done <= 1'b0;
            line_base  <= '0;
        end else begin
            state      <= state_nxt;
            issue_cnt  <= issue_cnt_nxt;
            recv_cnt   <= recv_cnt_nxt;
            issue_done <= issue_done_nxt;
            line_base  <= line_base_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        issue_cnt_nxt    = issue_cnt;
        recv_cnt_nxt     = recv_cnt;
        issue_done_nxt   = issue_done;
        line_base_nxt    = line_base;
        issue_fire       = 1'b0;
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_address     = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_nxt      = FILL;
                    line_base_nxt  = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    issue_cnt_nxt  = '0;
                    recv_cnt_nxt   = '0;
                    issue_done_nxt = 1'b0;
                end
            end
            FILL: begin
                fsm_busy       = 1'b1;
                mem_req        = !issue_done;
                memory_address = line_base + ADDR_W'({issue_word, 1'b0});
                issue_fire     = !issue_done && mem_ready;
                if (issue_fire) begin
                    issue_cnt_nxt = issue_cnt + 1'b1;
                    if (issue_cnt == CNT_W'(LINE_WORDS - 1)) begin
                        issue_done_nxt = 1'b1;
                    end
                end
                // Returns arrive in request order, so recv_cnt alone locates each word.
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_address     = line_base + ADDR_W'({recv_word, 1'b0});
                    fill_data        = memory_data_in;
                    recv_cnt_nxt     = recv_cnt + 1'b1;
                    if (recv_cnt == CNT_W'(LINE_WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        state_nxt       = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a latency-configurable memory model plus
// queues of expected request/fill addresses checked as the DUT produces them.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        mem_ready;
    logic        memory_data_valid;
    logic [15:0] memory_data_in;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_address;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .mem_ready         (mem_ready),
        .memory_data_valid (memory_data_valid),
        .memory_data_in    (memory_data_in),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_address      (fill_address),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 4;
    int rets, accepts, busy_cycles, first_acc, last_acc, pat_cnt;
    bit bp_mode, hold_valid, stray;
    logic [15:0] req_q[$];
    logic [15:0] fill_q[$];
    logic [15:0] pa[$];
    int          pd[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] exp_addr(input logic [15:0] miss, input int k);
        logic [2:0] s;
`ifdef CRITICAL_WORD_FIRST_EN
        s = miss[3:1];
`else
        s = 3'd0;
`endif
        return (miss & 16'hFFF0) + {12'd0, s + 3'(k), 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_fill(input logic [15:0] miss);
        for (int k = 0; k < 8; k++) begin
            req_q.push_back(exp_addr(miss, k));
            fill_q.push_back(exp_addr(miss, k));
        end
    endtask

    // One clock: drive inputs after the falling edge, sample and score, advance.
    task automatic cycle();
        logic [15:0] e;
        mem_ready = bp_mode ? (pat_cnt % 3 == 0) : 1'b1;
        pat_cnt++;
        if (stray) begin
            memory_data_valid = 1'b1;
            memory_data_in    = 16'($urandom);
        end else if (!hold_valid && pa.size() > 0 && pd[0] <= cyc) begin
            memory_data_valid = 1'b1;
            memory_data_in    = mem_word(pa.pop_front());
            void'(pd.pop_front());
        end else begin
            memory_data_valid = 1'b0;
            memory_data_in    = 16'($urandom);
        end
        #1;
        if (fsm_busy) busy_cycles++;
        if (!fsm_busy) begin
            chk("idle_mem_req", mem_req, 0);
            chk("idle_mem_addr", memory_address, 0);
            chk("idle_fill_addr", fill_address, 0);
            chk("idle_fill_data", fill_data, 0);
        end
        if (mem_req) begin
            if (req_q.size() == 0) begin
                chk("req_extra", mem_req, 0);
            end else begin
                chk("req_addr", memory_address, req_q[0]);
                if (mem_ready) begin
                    pa.push_back(memory_address);
                    pd.push_back(cyc + lat);
                    void'(req_q.pop_front());
                    if (accepts == 0) first_acc = cyc;
                    last_acc = cyc;
                    accepts++;
                end
            end
        end
        if (write_data_array) begin
            if (fill_q.size() == 0) begin
                chk("write_extra", write_data_array, 0);
            end else begin
                e = fill_q.pop_front();
                chk("fill_addr", fill_address, e);
                chk("fill_data", fill_data, mem_word(e));
                chk("tag_strobe", write_tag_array, (rets % 8 == 7));
                rets++;
            end
        end else begin
            chk("tag_no_write", write_tag_array, 0);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_scenario(input int l, input bit bp);
        lat = l; bp_mode = bp; pat_cnt = 0;
        rets = 0; accepts = 0; busy_cycles = 0; first_acc = 0; last_acc = 0;
    endtask

    task automatic do_miss(input logic [15:0] a);
        miss_detected = 1'b1;
        miss_address  = a;
        cycle();
        miss_detected = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (fill_q.size() == 0 && pa.size() == 0 && !fsm_busy) break;
            cycle();
        end
        chk(tag, (fill_q.size() == 0 && pa.size() == 0 && !fsm_busy), 1);
    endtask

    initial begin
        int rises, gap;
        bit prev;
        rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
        mem_ready = 1'b0; memory_data_valid = 1'b0; memory_data_in = '0;
        bp_mode = 0; hold_valid = 0; stray = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", fsm_busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", memory_address, 0);
        chk("rst_write", write_data_array, 0);
        chk("rst_fill_addr", fill_address, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_tag", write_tag_array, 0);
        rst_n = 1'b1;

        start_scenario(4, 0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("idle_busy", fsm_busy, 0);
        end

        // Basic in-order fill, latency 4.
        start_scenario(4, 0);
        push_fill(16'h1236);
        do_miss(16'h1236);
        wait_done("basic_done");
        chk("basic_busy_cycles", busy_cycles, 12);
        chk("basic_accepts", accepts, 8);
        chk("basic_req_span", last_acc - first_acc, 7);
        chk("basic_tags", rets, 8);

        // Backpressure with mem_ready pattern 1,0,0.
        start_scenario(3, 1);
        push_fill(16'h1236);
        do_miss(16'h1236);
        wait_done("bp_done");
        chk("bp_accepts", accepts, 8);
        chk("bp_req_left", req_q.size(), 0);

        // Reset after the third return, then stray returns must be ignored.
        start_scenario(2, 0);
        push_fill(16'h1236);
        do_miss(16'h1236);
        for (int i = 0; i < 100 && rets < 3; i++) cycle();
        chk("mid_rets", rets, 3);
        rst_n = 1'b0; hold_valid = 1'b1;
        cycle();
        rst_n = 1'b1; hold_valid = 1'b0;
        req_q.delete(); fill_q.delete(); pa.delete(); pd.delete();
        stray = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stray_busy", fsm_busy, 0);
        end
        stray = 1'b0;

        // Back-to-back misses at the top of memory, miss held high.
        start_scenario(2, 0);
        push_fill(16'hFFF2);
        push_fill(16'hFFF2);
        miss_detected = 1'b1;
        miss_address  = 16'hFFF2;
        rises = 0; gap = 0; prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (fsm_busy && !prev) rises++;
            if (rises >= 2) miss_detected = 1'b0;
            if (rises == 1 && !fsm_busy) gap++;
            prev = fsm_busy;
            if (rises >= 2 && rets == 16 && !fsm_busy) break;
        end
        miss_detected = 1'b0;
        chk("b2b_rises", rises, 2);
        chk("b2b_gap", gap, 1);
        chk("b2b_rets", rets, 16);
        chk("b2b_accepts", accepts, 16);

        // Mid-line miss: critical-word-first order when enabled, in-order otherwise.
        start_scenario(1, 0);
        push_fill(16'h123A);
        do_miss(16'h123A);
        wait_done("cwf_done");
        chk("cwf_rets", rets, 8);
        chk("cwf_busy_cycles", busy_cycles, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
